// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock.
// Result is {remainder, quotient}, held until the requester drops start_i.
module div #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t              r_state, w_state_n;
    logic [5:0]          r_cnt, w_cnt_n;
    logic [2*DATA_W:0]   r_dvd, w_dvd_n;
    logic [DATA_W-1:0]   r_dvs, w_dvs_n;
    logic                r_neg_q, w_neg_q_n;
    logic                r_neg_r, w_neg_r_n;
    logic [2*DATA_W-1:0] r_result, w_result_n;
    logic                r_ready, w_ready_n;

    logic [DATA_W-1:0]   w_abs1, w_abs2;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_quot, w_rem;

    assign w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    assign w_diff = r_dvd[2*DATA_W:DATA_W] - {1'b0, r_dvs};

    // Restore the signs: quotient by operand XOR, remainder follows the dividend.
    assign w_quot = r_neg_q ? (~r_dvd[DATA_W-1:0] + 1'b1) : r_dvd[DATA_W-1:0];
    assign w_rem  = r_neg_r ? (~r_dvd[2*DATA_W:DATA_W+1] + 1'b1) : r_dvd[2*DATA_W:DATA_W+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_dvd    <= w_dvd_n;
            r_dvs    <= w_dvs_n;
            r_neg_q  <= w_neg_q_n;
            r_neg_r  <= w_neg_r_n;
            r_result <= w_result_n;
            r_ready  <= w_ready_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_dvd_n    = r_dvd;
        w_dvs_n    = r_dvs;
        w_neg_q_n  = r_neg_q;
        w_neg_r_n  = r_neg_r;
        w_result_n = r_result;
        w_ready_n  = r_ready;
        unique case (r_state)
            S_FREE: begin
                w_ready_n  = 1'b0;
                w_result_n = '0;
                if (start_i && !annul_i) begin
                    w_neg_q_n = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    w_neg_r_n = signed_div_i & opdata1_i[DATA_W-1];
                    if (opdata2_i == '0) begin
                        w_state_n = S_BYZERO;
                    end else begin
                        w_state_n = S_ON;
                        w_cnt_n   = '0;
                        w_dvd_n   = {{DATA_W{1'b0}}, w_abs1, 1'b0};
                        w_dvs_n   = w_abs2;
                    end
                end
            end
            S_BYZERO: begin
                if (annul_i) begin
                    w_state_n  = S_FREE;
                    w_ready_n  = 1'b0;
                    w_result_n = '0;
                end else begin
                    w_state_n  = S_END;
                    w_ready_n  = 1'b1;
                    w_result_n = '0;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    w_state_n  = S_FREE;
                    w_ready_n  = 1'b0;
                    w_result_n = '0;
                end else if (r_cnt != 6'd32) begin
                    if (w_diff[DATA_W]) begin
                        w_dvd_n = {r_dvd[2*DATA_W-1:0], 1'b0};
                    end else begin
                        w_dvd_n = {w_diff[DATA_W-1:0], r_dvd[DATA_W-1:0], 1'b1};
                    end
                    w_cnt_n = r_cnt + 6'd1;
                end else begin
                    w_state_n  = S_END;
                    w_ready_n  = 1'b1;
                    w_result_n = {w_rem, w_quot};
                end
            end
            S_END: begin
                if (!start_i) begin
                    w_state_n  = S_FREE;
                    w_ready_n  = 1'b0;
                    w_result_n = '0;
                end
            end
            default: begin
                w_state_n = S_FREE;
            end
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: table of operand/result vectors plus
// hand-written annul, divide-by-zero and asynchronous reset sequences.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_pass;
    int n_total;

    div #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Launch, count edges until ready, check result, hold, then release.
    task automatic do_op(input string nm, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready_o && n < 100);
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " result"}, result_o, exp);
        opdata1_i = 32'h1234_5678;
        opdata2_i = 32'h0000_0003;
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " hold result"}, result_o, exp);
        chk({nm, " hold ready"}, 64'(ready_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " release ready"}, 64'(ready_o), 64'd0);
        chk({nm, " release result"}, result_o, 64'd0);
    endtask

    vec_t vecs[11];

    initial begin
        bit saw;
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 34};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 34};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 34};
        vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 34};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 34};
        vecs[6]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFFFFFE_0000000E, 34};
        vecs[7]  = '{1'b0, 32'h1234_5678,  32'd1000,       64'h00000380_0004A90B, 34};
        vecs[8]  = '{1'b1, 32'd0,          32'd5,          64'h00000000_00000000, 34};
        vecs[9]  = '{1'b0, 32'd5,          32'd0,          64'h00000000_00000000, 2};
        vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFF9,  64'h00000000_00000001, 34};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #2;
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].lat);
        end

        // Divide by zero with operands disturbed right after capture.
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'd77;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        chk("byzero ready after E0", 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        chk("byzero ready after E1", 64'(ready_o), 64'd1);
        chk("byzero result", result_o, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("byzero ignores new operands", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("byzero release", 64'(ready_o), 64'd0);

        // Annul sampled at E11 of a 100/7 operation.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) saw = 1'b1;
        end
        chk("annul no ready", 64'(saw), 64'd0);
        do_op("after annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

        // Async reset mid-operation, then in END.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst in ON ready", 64'(ready_o), 64'd0);
        chk("rst in ON result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) saw = 1'b1;
        end
        chk("rst in ON no result", 64'(saw), 64'd0);
        do_op("after rst ON", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);

        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (34) @(posedge clk);
        #1;
        chk("pre-rst END ready", 64'(ready_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst in END ready", 64'(ready_o), 64'd0);
        chk("rst in END result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_op("after rst END", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
